// File: rtl/mfun_pkg.sv
// mfun_pkg: shared constants, types and helper functions for the mfun M-sequence generator.
//
// Contents:
//   DefWidth / DefPeriod  default LFSR length and frame length
//   MaxWidth              widest LFSR the helper functions support
//   mode_e                shift or reload cycle
//   parity_fb()           feedback bit = XOR-reduction of (state & taps)
//   guard_seed()          value loaded into the LFSR on reset/reload
//
// Build option: MFUN_ZERO_GUARD_EN -- when defined, an all-zero seed is replaced by 1 so the
// LFSR cannot lock up at zero. When undefined the seed is loaded verbatim.
package mfun_pkg;

    localparam int unsigned DefWidth  = 4;
    localparam int unsigned DefPeriod = 15;
    localparam int unsigned MaxWidth  = 64;

    typedef enum logic {
        ModeShift,
        ModeReload
    } mode_e;

    // Operands arrive zero-extended to MaxWidth; the extra zero bits do not change the parity.
    function automatic logic parity_fb(logic [MaxWidth-1:0] state, logic [MaxWidth-1:0] taps);
        return ^(state & taps);
    endfunction

    function automatic logic [MaxWidth-1:0] guard_seed(logic [MaxWidth-1:0] seed);
`ifdef MFUN_ZERO_GUARD_EN
        return (seed == '0) ? MaxWidth'(1) : seed;
`else
        return seed;
`endif
    endfunction

endpackage

// File: rtl/mfun_lfsr.sv
// mfun_lfsr: Fibonacci LFSR with programmable taps and a load path.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset; loads the (guarded) seed
//   mode  in   ModeShift shifts, ModeReload loads the (guarded) seed
//   seed  in   WIDTH  start phase
//   taps  in   WIDTH  feedback tap mask, bit i=1 puts state bit i into the XOR
//   fb    out  feedback bit of the current state (combinational)
//   next  out  WIDTH  shifted state the register moves to in a shift cycle
//
// Zero-seed handling follows MFUN_ZERO_GUARD_EN through mfun_pkg::guard_seed().
module mfun_lfsr
    import mfun_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth  // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] taps,
    output logic             fb,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        fb      = parity_fb(MaxWidth'(state_q), MaxWidth'(taps));
        next    = {state_q[WIDTH-2:0], fb};
        state_d = next;
        if (rst || mode == ModeReload) begin
            state_d = WIDTH'(guard_seed(MaxWidth'(seed)));
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

endmodule

// File: rtl/mfun.sv
// mfun: programmable-width M-sequence generator with framed output.
//
// Emits one pseudo-random bit per clock on sum. After PERIOD shifts, control pulses for one cycle
// and fase_new holds the state reached; the following cycle reloads the LFSR from fase, so a
// frame is PERIOD+1 cycles long.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset, priority over everything
//   fase      in   WIDTH  start phase, sampled at reset and in the reload cycle
//   type_f    in   WIDTH  tap mask, sampled every cycle
//   fase_new  out  WIDTH  state reached at end of frame, held until the next frame end
//   sum       out  generated bit, combinational from the state register
//   control   out  one-cycle end-of-frame strobe, registered
//
// Build option: MFUN_ZERO_GUARD_EN replaces an all-zero loaded seed with 1.
module mfun
    import mfun_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned PERIOD = DefPeriod  // 1 .. 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fase,
    input  logic [WIDTH-1:0] type_f,
    output logic [WIDTH-1:0] fase_new,
    output logic             sum,
    output logic             control
);

    localparam int unsigned      CntW    = $clog2(PERIOD + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(PERIOD - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             control_q, control_d;
    logic [WIDTH-1:0] fase_new_q, fase_new_d;
    logic [WIDTH-1:0] next_state;
    mode_e            mode;

    // The cycle after the strobe is the reload cycle.
    assign mode = control_q ? ModeReload : ModeShift;

    mfun_lfsr #(
        .WIDTH(WIDTH)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .mode(mode),
        .seed(fase),
        .taps(type_f),
        .fb  (sum),
        .next(next_state)
    );

    always_comb begin
        cnt_d      = cnt_q;
        control_d  = 1'b0;
        fase_new_d = fase_new_q;
        if (mode == ModeShift) begin
            if (cnt_q == CntLast) begin
                cnt_d      = '0;
                control_d  = 1'b1;
                fase_new_d = next_state;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            control_q  <= 1'b0;
            fase_new_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            control_q  <= control_d;
            fase_new_q <= fase_new_d;
        end
    end

    assign fase_new = fase_new_q;
    assign control  = control_q;

endmodule

// File: tb/tb_mfun.sv
// tb_mfun: self-checking bench for mfun (default WIDTH=4/PERIOD=15 instance plus a PERIOD=5
// instance). A frame-level reference model tracks the LFSR state with plain arithmetic.
module tb_mfun;

    localparam int W  = 4;
    localparam int P  = 15;
    localparam int P5 = 5;

    logic         clk = 1'b0;
    logic         rst, rst5;
    logic [W-1:0] fase, type_f, fase5, type_f5;
    logic [W-1:0] fase_new, fase_new5;
    logic         sum, sum5, control, control5;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] m_state;
    int           m_shifts;
    logic         m_ctrl;
    logic [W-1:0] m_fase_new;

    always #5 clk = ~clk;

    mfun #(.WIDTH(W), .PERIOD(P)) dut (
        .clk     (clk),
        .rst     (rst),
        .fase    (fase),
        .type_f  (type_f),
        .fase_new(fase_new),
        .sum     (sum),
        .control (control)
    );

    mfun #(.WIDTH(W), .PERIOD(P5)) dut5 (
        .clk     (clk),
        .rst     (rst5),
        .fase    (fase5),
        .type_f  (type_f5),
        .fase_new(fase_new5),
        .sum     (sum5),
        .control (control5)
    );

    function automatic logic par(input logic [W-1:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    function automatic logic [W-1:0] seed_of(input logic [W-1:0] v);
`ifdef MFUN_ZERO_GUARD_EN
        return (v == 0) ? W'(1) : v;
`else
        return v;
`endif
    endfunction

    // Frame-level model: PERIOD shifts, then a strobe, then a reload from fase.
    task automatic model_edge();
        logic [W-1:0] nxt;
        if (rst) begin
            m_state    = seed_of(fase);
            m_shifts   = 0;
            m_ctrl     = 1'b0;
            m_fase_new = '0;
        end else if (m_ctrl) begin
            m_state = seed_of(fase);
            m_ctrl  = 1'b0;
        end else begin
            nxt      = W'((int'(m_state) * 2 + int'(par(m_state & type_f))) % (1 << W));
            m_state  = nxt;
            m_shifts = m_shifts + 1;
            if (m_shifts == P) begin
                m_shifts   = 0;
                m_ctrl     = 1'b1;
                m_fase_new = nxt;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fase = 4'b0001; type_f = 4'b1001;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (control !== 1'b0) begin errors++; $display("FAIL reset_control got %b want 0", control); end
        checks++;
        if (fase_new !== 4'b0000) begin errors++; $display("FAIL reset_fase_new got %b want 0000", fase_new); end
        checks++;
        if (sum !== 1'b1) begin errors++; $display("FAIL reset_sum got %b want 1", sum); end
    endtask

    task automatic test_sequence();
        logic [W-1:0] seq [15] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101,
                                   4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001};
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (sum !== par(seq[i] & 4'b1001)) begin
                errors++; $display("FAIL seq_sum[%0d] got %b want %b", i, sum, par(seq[i] & 4'b1001));
            end
            checks++;
            if (control !== (i == 14)) begin
                errors++; $display("FAIL seq_control[%0d] got %b want %b", i, control, i == 14);
            end
        end
        checks++;
        if (fase_new !== 4'b0001) begin errors++; $display("FAIL seq_fase_new got %b want 0001", fase_new); end
    endtask

    task automatic test_chain();
        int last = 15;
        int pulses = 0;
        for (int c = 16; c < 16 + 48; c++) begin
            if (control) fase = fase_new;
            tick();
            checks++;
            if (sum !== par(m_state & type_f) || control !== m_ctrl) begin
                errors++;
                $display("FAIL chain[%0d] got sum=%b ctrl=%b want sum=%b ctrl=%b", c, sum, control,
                         par(m_state & type_f), m_ctrl);
            end
            if (control) begin
                pulses++;
                checks++;
                if (c - last != 16 || fase_new !== 4'b0001) begin
                    errors++;
                    $display("FAIL chain_period got gap=%0d fase_new=%b want gap=16 fase_new=0001",
                             c - last, fase_new);
                end
                last = c;
            end
        end
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL chain_pulses got %0d want 3", pulses); end
    endtask

    task automatic test_taps();
        logic [W-1:0] tbl [8] = '{4'b1010, 4'b0100, 4'b1001, 4'b0011, 4'b0111, 4'b1110, 4'b1101,
                                  4'b1010};
        rst = 1'b1; fase = 4'b0101; type_f = 4'b0101;
        tick();
        rst = 1'b0;
        checks++;
        if (sum !== 1'b0) begin errors++; $display("FAIL taps_sum_init got %b want 0", sum); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (sum !== par(tbl[i] & 4'b0101) || sum !== par(m_state & type_f)) begin
                errors++;
                $display("FAIL taps_sum[%0d] got %b want %b", i, sum, par(tbl[i] & 4'b0101));
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        rst = 1'b1; fase = 4'b0001; type_f = 4'b1001;
        tick();
        rst = 1'b0;
        repeat (16 + 7) tick();
        checks++;
        if (fase_new !== 4'b0001) begin errors++; $display("FAIL mid_pre_fase_new got %b want 0001", fase_new); end
        rst = 1'b1; fase = 4'b1000;
        tick();
        rst = 1'b0;
        checks++;
        if (control !== 1'b0 || fase_new !== 4'b0000 || sum !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got ctrl=%b fase_new=%b sum=%b want 0 0000 1", control, fase_new, sum);
        end
        while (!control && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 15) begin errors++; $display("FAIL mid_restart got %0d edges want 15", n); end
    endtask

    task automatic test_zero_seed();
        int pulses = 0;
        rst = 1'b1; fase = 4'b0000; type_f = 4'b1001;
        tick();
        rst = 1'b0;
        checks++;
`ifdef MFUN_ZERO_GUARD_EN
        if (sum !== 1'b1) begin errors++; $display("FAIL zero_guard_sum got %b want 1", sum); end
`else
        if (sum !== 1'b0) begin errors++; $display("FAIL zero_sum got %b want 0", sum); end
`endif
        for (int i = 0; i < 32; i++) begin
            tick();
            if (control) pulses++;
            checks++;
            if (sum !== par(m_state & type_f) || control !== m_ctrl || fase_new !== m_fase_new) begin
                errors++;
                $display("FAIL zero_run[%0d] got sum=%b ctrl=%b fn=%b want %b %b %b", i, sum, control,
                         fase_new, par(m_state & type_f), m_ctrl, m_fase_new);
            end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL zero_pulses got %0d want 2", pulses); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            fase = W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) type_f = W'($urandom_range(0, 15));
            tick();
            checks++;
            if (sum !== par(m_state & type_f) || control !== m_ctrl || fase_new !== m_fase_new) begin
                errors++;
                $display("FAIL random[%0d] got sum=%b ctrl=%b fn=%b want %b %b %b", i, sum, control,
                         fase_new, par(m_state & type_f), m_ctrl, m_fase_new);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_period5();
        rst5 = 1'b1; fase5 = 4'b0001; type_f5 = 4'b1001;
        @(posedge clk); #1;
        rst5 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            checks++;
            if (control5 !== (e == 5 || e == 11)) begin
                errors++; $display("FAIL p5_control[%0d] got %b want %b", e, control5, e == 5 || e == 11);
            end
            if (e == 5 || e == 11) begin
                checks++;
                if (fase_new5 !== 4'b1101) begin
                    errors++; $display("FAIL p5_fase_new[%0d] got %b want 1101", e, fase_new5);
                end
            end
            if (e == 6) begin
                checks++;
                if (sum5 !== 1'b1) begin errors++; $display("FAIL p5_reload_sum got %b want 1", sum5); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst5 = 1'b1;
        fase = '0; type_f = '0; fase5 = '0; type_f5 = '0;
        test_reset();
        test_sequence();
        test_chain();
        test_taps();
        test_mid_reset();
        test_zero_seed();
        test_random();
        test_period5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
